// File: rtl/memory_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals for the memory arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface memory_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_abort;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic [31:0] d_wdata;
  logic        d_size;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_abort;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_size;
  logic [1:0]  mem_prot;
  logic [1:0]  mem_trans;
  logic [31:0] mem_rdata;
  logic        mem_abort;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_write, d_wdata, d_size, mem_rdata, mem_abort,
    output if_gnt, if_rvalid, if_rdata, if_abort, d_gnt, d_rvalid, d_rdata, d_abort,
    output mem_addr, mem_wdata, mem_write, mem_size, mem_prot, mem_trans
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_write, d_wdata, d_size, mem_rdata, mem_abort,
    input  if_gnt, if_rvalid, if_rdata, if_abort, d_gnt, d_rvalid, d_rdata, d_abort,
    input  mem_addr, mem_wdata, mem_write, mem_size, mem_prot, mem_trans
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-master (fetch/data) arbiter onto one memory port: grant in N, address phase N+1, response N+2.
// Grants are combinational with data priority; fetch is forced through after FETCH_STARVE_LIMIT data wins.
module memory_arbiter #(
  parameter logic [3:0] FETCH_STARVE_LIMIT = 4'd4,
  parameter logic [1:0] FETCH_PROT         = 2'b10,
  parameter logic [1:0] DATA_PROT          = 2'b11
) (
  input logic              clk,
  input logic              reset,
  memory_arbiter_if.slave  bus
);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  logic [3:0]  starve_cnt;
  logic        ap_data;
  logic        rsp_vld;
  logic        rsp_data;

  logic        if_win;
  logic        gnt_any;
  logic        new_data;
  logic        new_write;
  logic [31:0] new_addr;
  logic        seq;

  always_comb begin
    if_win    = bus.if_req && (!bus.d_req || (starve_cnt == FETCH_STARVE_LIMIT));
    new_data  = !reset && bus.d_req && !if_win;
    gnt_any   = !reset && (bus.if_req || bus.d_req);
    new_addr  = new_data ? bus.d_addr : bus.if_addr;
    new_write = new_data && bus.d_write;
    // The registered address phase doubles as the previous-transfer record.
    seq       = (bus.mem_trans != TRANS_IDLE) && (ap_data == new_data) &&
                (bus.mem_write == new_write) && (new_addr == bus.mem_addr + 32'd1);
  end

  assign bus.if_gnt    = !reset && if_win;
  assign bus.d_gnt     = new_data;
  assign bus.if_rvalid = !reset && rsp_vld && !rsp_data;
  assign bus.d_rvalid  = !reset && rsp_vld && rsp_data;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.if_abort  = bus.if_rvalid && bus.mem_abort;
  assign bus.d_abort   = bus.d_rvalid && bus.mem_abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt    <= 4'd0;
      ap_data       <= 1'b0;
      rsp_vld       <= 1'b0;
      rsp_data      <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_write <= 1'b0;
      bus.mem_size  <= 1'b0;
      bus.mem_prot  <= 2'b00;
      bus.mem_trans <= TRANS_IDLE;
    end else begin
      rsp_vld  <= (bus.mem_trans != TRANS_IDLE);
      rsp_data <= ap_data;

      if (!bus.if_req || bus.if_gnt) begin
        starve_cnt <= 4'd0;
      end else if (bus.d_gnt && (starve_cnt != FETCH_STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (gnt_any) begin
        bus.mem_trans <= seq ? TRANS_SEQ : TRANS_NONSEQ;
        bus.mem_addr  <= new_addr;
        bus.mem_write <= new_write;
        ap_data       <= new_data;
        if (new_data) begin
          bus.mem_wdata <= bus.d_wdata;
          bus.mem_size  <= bus.d_size;
          bus.mem_prot  <= DATA_PROT;
        end else begin
          bus.mem_size  <= 1'b1;
          bus.mem_prot  <= FETCH_PROT;
        end
      end else begin
        // Idle: address, data, size and prot keep their last values.
        bus.mem_trans <= TRANS_IDLE;
        bus.mem_write <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized bench for memory_arbiter against a transaction-level reference model.
// A simple registered memory with address-dependent aborts sits on the memory port.
module tb_memory_arbiter;
  localparam logic [3:0] LIMIT = 4'd4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  memory_arbiter_if bus ();

  memory_arbiter #(
    .FETCH_STARVE_LIMIT(LIMIT),
    .FETCH_PROT        (2'b10),
    .DATA_PROT         (2'b11)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return 32'h9E37_79B9 * 32'(a + 1);
  endfunction

  // Memory: read data and abort registered one cycle after an address phase.
  logic [31:0] mem_arr [256];
  bit          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
      mem_loaded = 1'b1;
    end
    if (bus.mem_trans != 2'b00 && bus.mem_write) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_trans != 2'b00 && !bus.mem_write) ? mem_arr[bus.mem_addr[7:0]] : $urandom;
    bus.mem_abort <= (bus.mem_trans != 2'b00) ? (bus.mem_addr[2:0] == 3'd7) : 1'($urandom_range(0, 1));
  end

  // Reference model state: expected address phase, expected response, expected memory.
  logic [31:0] ref_mem [256];
  logic [31:0] e_addr, e_wdata;
  logic        e_write, e_size, e_own_d;
  logic [1:0]  e_prot, e_trans;
  logic        r_vld, r_own_d, r_write, r_abort;
  logic [31:0] r_rdata;
  int          cons_d;
  int          obs_run;
  logic        last_gi, last_gd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        eg_i, eg_d, n_d, n_w, seq, exp_ir, exp_dr;
    logic [31:0] n_a;
    @(negedge clk);
    if (reset) begin
      eg_i = 1'b0;
      eg_d = 1'b0;
    end else begin
      eg_d = bus.d_req && !(bus.if_req && cons_d >= int'(LIMIT));
      eg_i = bus.if_req && !eg_d;
    end
    chk("if_gnt", 32'(bus.if_gnt), 32'(eg_i));
    chk("d_gnt",  32'(bus.d_gnt),  32'(eg_d));
    chk("mem_trans", 32'(bus.mem_trans), 32'(e_trans));
    chk("mem_write", 32'(bus.mem_write), 32'(e_write));
    chk("mem_addr",  bus.mem_addr,  e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("mem_size",  32'(bus.mem_size), 32'(e_size));
    chk("mem_prot",  32'(bus.mem_prot), 32'(e_prot));

    exp_ir = !reset && r_vld && !r_own_d;
    exp_dr = !reset && r_vld && r_own_d;
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(exp_ir));
    chk("d_rvalid",  32'(bus.d_rvalid),  32'(exp_dr));
    chk("if_abort",  32'(bus.if_abort),  32'(exp_ir && r_abort));
    chk("d_abort",   32'(bus.d_abort),   32'(exp_dr && r_abort));
    if (exp_ir) chk("if_rdata", bus.if_rdata, r_rdata);
    if (exp_dr && !r_write) chk("d_rdata", bus.d_rdata, r_rdata);

    if (bus.d_gnt && bus.if_req) obs_run++;
    else if (bus.if_gnt || !bus.if_req) obs_run = 0;
    chk("starve_bound", 32'(obs_run <= int'(LIMIT)), 32'd1);

    // The memory sees any address phase on the bus, even one cut off by reset.
    if (e_trans != 2'b00 && e_write) ref_mem[e_addr[7:0]] = e_wdata;
    if (reset) begin
      r_vld = 0; e_trans = 0; e_addr = 0; e_wdata = 0; e_write = 0;
      e_size = 0; e_prot = 0; e_own_d = 0; cons_d = 0;
    end else begin
      r_vld   = (e_trans != 2'b00);
      r_own_d = e_own_d;
      r_write = e_write;
      r_rdata = ref_mem[e_addr[7:0]];
      r_abort = (e_addr[2:0] == 3'd7);
      if (eg_i || eg_d) begin
        n_d = eg_d;
        n_a = eg_d ? bus.d_addr : bus.if_addr;
        n_w = eg_d && bus.d_write;
        seq = (e_trans != 2'b00) && (e_own_d == n_d) && (!n_d || e_write == n_w) &&
              (n_a == e_addr + 32'd1);
        e_trans = seq ? 2'b11 : 2'b10;
        e_addr  = n_a;
        e_write = n_w;
        e_own_d = n_d;
        if (eg_d) begin
          e_wdata = bus.d_wdata;
          e_size  = bus.d_size;
          e_prot  = 2'b11;
        end else begin
          e_size  = 1'b1;
          e_prot  = 2'b10;
        end
      end else begin
        e_trans = 2'b00;
        e_write = 1'b0;
      end
      if (!bus.if_req || eg_i) cons_d = 0;
      else if (eg_d && cons_d < int'(LIMIT)) cons_d++;
    end
    last_gi = eg_i;
    last_gd = eg_d;
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic req, input logic [31:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic set_d(input logic req, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic size);
    bus.d_req   = req;
    bus.d_addr  = addr;
    bus.d_write = wr;
    bus.d_wdata = wdata;
    bus.d_size  = size;
  endtask

  task automatic idle(input int n);
    set_if(1'b0, 32'd0);
    set_d(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    set_if(1'b0, 32'd0);
    set_d(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    e_addr = 0; e_wdata = 0; e_write = 0; e_size = 0; e_own_d = 0; e_prot = 0; e_trans = 0;
    r_vld = 0; r_own_d = 0; r_write = 0; r_abort = 0; r_rdata = 0;
    cons_d = 0; obs_run = 0; last_gi = 0; last_gd = 0;

    // Reset state, then release with requests pending.
    tick(); tick();
    reset = 1'b0;
    tick();

    // Sequential fetch burst 0,1,2.
    set_if(1'b1, 32'd0); tick();
    set_if(1'b1, 32'd1); tick();
    set_if(1'b1, 32'd2); tick();
    idle(3);

    // Simultaneous fetch and data read: data first.
    set_if(1'b1, 32'h10);
    set_d(1'b1, 32'h20, 1'b0, 32'd0, 1'b0);
    tick();
    set_d(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    tick();
    idle(3);

    // Both held continuously: starvation bound forces periodic fetch grants.
    set_if(1'b1, 32'h80);
    set_d(1'b1, 32'h90, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (last_gi) bus.if_addr = bus.if_addr + 32'd1;
      if (last_gd) bus.d_addr  = bus.d_addr + 32'd1;
    end
    idle(3);

    // Write then read of the same word.
    set_d(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF, 1'b1); tick();
    set_d(1'b1, 32'h40, 1'b0, 32'd0, 1'b1);         tick();
    idle(3);

    // Reset right after a data grant drops the transfer.
    set_d(1'b1, 32'h44, 1'b0, 32'd0, 1'b0); tick();
    set_d(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1; tick();
    reset = 1'b0;
    set_if(1'b1, 32'h60); tick();
    idle(3);

    // Aborted data read followed by a clean fetch.
    set_d(1'b1, 32'h47, 1'b0, 32'd0, 1'b1); tick();
    set_d(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    set_if(1'b1, 32'h50); tick();
    idle(3);

    // Address wrap counts as sequential.
    set_if(1'b1, 32'hFFFF_FFFF); tick();
    set_if(1'b1, 32'h0000_0000); tick();
    idle(3);

    // Randomized traffic; each requester holds its request until granted.
    for (int c = 0; c < 400; c++) begin
      if (!bus.if_req || last_gi) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = ($urandom_range(0, 2) != 0) ? bus.if_addr + 32'd1 : 32'($urandom_range(0, 255));
      end
      if (!bus.d_req || last_gd) begin
        bus.d_req   = ($urandom_range(0, 2) != 0);
        bus.d_addr  = ($urandom_range(0, 1) != 0) ? bus.d_addr + 32'd1 :
                      (($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255)));
        bus.d_write = ($urandom_range(0, 3) == 0);
        bus.d_wdata = $urandom;
        bus.d_size  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single word-addressed memory interface between two requesters: the instruction fetch port and the data (load/store) port of the processor core.
- Arbitrates every cycle and drives the memory address/control phase from registers.
- Returns read data one cycle after the address phase and routes it to the owning requester.
- Gives data accesses priority, and bounds how long fetch can be starved.

Parameters:
- FETCH_STARVE_LIMIT, 4: maximum number of consecutive data grants while if_req is held; after that, fetch is forced a grant. Legal range is 1..15.
- FETCH_PROT, 2'b10: mem_prot value for fetch transfers.
- DATA_PROT, 2'b11: mem_prot value for data transfers.

Ports:
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch word address
- if_gnt  out  1  combinational; fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- if_abort  out  1  fetch abort, qualified by if_rvalid
- d_req  in  1  data request; held with its qualifiers until d_gnt
- d_addr  in  32  data word address
- d_write  in  1  1 = write, 0 = read
- d_wdata  in  32  write data
- d_size  in  1  transfer size, passed through to mem_size
- d_gnt  out  1  combinational; data request accepted this cycle
- d_rvalid  out  1  data response valid; asserted for both reads and writes
- d_rdata  out  32  data read data; don't-care for writes
- d_abort  out  1  data abort, qualified by d_rvalid
- mem_addr  out  32  memory address (registered)
- mem_wdata  out  32  memory write data (registered)
- mem_write  out  1  memory write enable (registered)
- mem_size  out  1  memory transfer size (registered); 1 for fetch
- mem_prot  out  2  memory protection/type (registered)
- mem_trans  out  2  transfer type: 00 IDLE, 10 NONSEQ, 11 SEQ (registered)
- mem_rdata  in  32  memory read data; registered by memory, valid the cycle after the address phase
- mem_abort  in  1  memory abort, valid with mem_rdata

Behaviour:
- Reset is synchronous, active-high and has priority over everything. While reset is high, at each clock edge:
  - all registered outputs clear to 0, so mem_trans = 00;
  - the starve counter, owner registers and the previous-transfer record all clear.
- Gating during reset: if_gnt and d_gnt are forced to 0 while reset is high.
  - if_rvalid and d_rvalid are 0 in every cycle while reset is high, and in the first cycle after reset deasserts.
  - Any transfer in flight when reset asserts is dropped and produces no response.
- Pipeline, with no stalls:
  - Cycle N: the request is granted (gnt = 1).
  - Cycle N+1: the address phase drives the mem_* outputs.
  - Cycle N+2: the response (rvalid) arrives.
  - Throughput is one transfer per cycle, and back-to-back grants are allowed.
- Grant rules, evaluated combinationally each cycle:
  - At most one of if_gnt and d_gnt is high in any cycle.
  - If only one requester is asserted, it is granted.
  - If both are asserted, d_req wins unless starve_cnt == FETCH_STARVE_LIMIT, in which case if_req wins.
  - If neither is asserted, no grant is given and the next address phase is IDLE.
- Starve counter (4 bits):
  - Increments on each d_gnt while if_req is high.
  - Clears on if_gnt, and on any cycle in which if_req is low.
  - Saturates at FETCH_STARVE_LIMIT.
- Address phase, registered at the edge ending the grant cycle.
  - On a fetch grant:
    - mem_addr = if_addr;
    - mem_write = 0;
    - mem_size = 1;
    - mem_prot = FETCH_PROT.
  - On a data grant:
    - mem_addr = d_addr;
    - mem_write = d_write;
    - mem_wdata = d_wdata;
    - mem_size = d_size;
    - mem_prot = DATA_PROT.
  - On no grant:
    - mem_trans = 00;
    - mem_write = 0;
    - mem_addr, mem_wdata, mem_size and mem_prot hold their previous values.
- Transfer type:
  - mem_trans = 11 (SEQ) when all of the following hold: the previous cycle was non-IDLE, it had the same owner, for data it had the same d_write, and the new address equals the previous address + 1 (32-bit wrap, so 0xFFFFFFFF followed by 0 counts as sequential).
  - Otherwise mem_trans = 10 (NONSEQ).
  - Any IDLE cycle breaks the sequence.
- Response phase:
  - The owner and write flag are registered alongside the address phase.
  - In the following cycle the owner's rvalid = 1; the owner's rdata = mem_rdata and abort = mem_abort.
  - The non-owner's rvalid and abort are 0.
  - rdata outputs pass mem_rdata through unconditionally; consumers qualify them with rvalid.
- Simultaneous events:
  - A grant and a response for different masters in the same cycle are independent.
  - A response for a master and a new grant to the same master in the same cycle are both legal.

Test Plan:
1. if_req held with if_addr = 0,1,2 and d_req = 0 → if_gnt for three consecutive cycles; mem_trans = 10,11,11; mem_prot = 10; if_rvalid two cycles after each grant, carrying memory words 0..2.
2. if_req (addr 0x10) and d_req read (addr 0x20) raised in the same cycle → d_gnt in cycle 0, if_gnt in cycle 1; mem_addr = 0x20 then 0x10; mem_trans = 10,10; d_rvalid in cycle 2, if_rvalid in cycle 3.
3. d_req and if_req both held continuously, with FETCH_STARVE_LIMIT = 4 → grant pattern D,D,D,D,F repeating; never more than 4 consecutive D grants while if_req is high.
4. Data write to 0x40 with 0xDEADBEEF, then a data read of 0x40 in the next cycle → mem_write = 1 then 0; the read's mem_trans = 10 (direction change); d_rdata = 0xDEADBEEF with d_rvalid.
5. reset asserted in the cycle after a d_gnt, held one cycle, then released → d_rvalid stays 0 in both reset-affected cycles; mem_trans = 00; all mem_* outputs are 0; normal grants resume the next cycle.
6. mem_abort driven to 1 during the response cycle of a data read → d_rvalid = 1 with d_abort = 1; if_abort = 0; a following fetch response shows if_abort = 0.
